wb_port_arb: RTL and testbench
==============================

# wb_port_arb

Arbiter and scheduler for the single register-file write port at the end of the rv32 pipeline. It merges two sources of write data: in-order writebacks from the pipeline WB stage, and out-of-order results from a multi-cycle unit (MDU: mul/div). MDU results are held in a small FIFO and drained into idle write-port cycles. A starvation counter forces draining by stalling the pipeline when needed. All register-file write outputs are registered.

## Interface
Parameters:
- FIFO_DEPTH, 2: MDU result buffer entries (power of two, ≥2).
- STARVE_MAX, 8: cycles a non-empty FIFO may go without a pop before forced drain (≥1).

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- pipe_valid  input  1  WB stage holds a valid instruction.
- pipe_wen  input  1  that instruction writes rd; request = pipe_valid & pipe_wen.
- pipe_rd  input  5  destination register.
- pipe_wdata  input  32  write data.
- pipe_stall  output  1  WB request not accepted this cycle; pipeline holds WB and upstream.
- mdu_valid  input  1  MDU presents a result.
- mdu_rd  input  5  MDU destination register.
- mdu_wdata  input  32  MDU result.
- mdu_ready  output  1  FIFO can accept; push = mdu_valid & mdu_ready.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  5  write address (registered).
- rf_wdata  output  32  write data (registered).

## Operation
- Two states:
  - PIPE_PRI: pipeline has priority.
  - MDU_FORCE: FIFO has priority; pipe_stall=1.
- pipe_stall = (state==MDU_FORCE). Decoded from registered state only; no combinational path from inputs.
- mdu_ready = (count < FIFO_DEPTH), from the registered count only.
- Grant in PIPE_PRI:
  - Pipe request present: the pipe wins.
  - Otherwise, if count>0: pop the FIFO head.
  - Otherwise: the port is idle.
- Grant in MDU_FORCE:
  - Pop the FIFO head every cycle; the pipe request is not consumed.
  - If count==0 on entry (not reachable, defensive), the port is idle.
- pipe_valid with pipe_wen=0 is a bubble and never occupies the port; a FIFO pop may use that cycle.
- Writes to rd==x0 are consumed normally but produce rf_we=0.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
  - A push and a pop in the same cycle are both performed; count is unchanged.
  - A push lands behind existing entries; there is no bypass from mdu_* directly to rf_*.
- Starvation counter starve_cnt:
  - Cleared when a pop occurs, when count==0, or in MDU_FORCE.
  - Otherwise increments in PIPE_PRI, saturating at STARVE_MAX.
- PIPE_PRI → MDU_FORCE when, after the cycle's update, either count_next==FIFO_DEPTH or starve_cnt_next==STARVE_MAX.
- MDU_FORCE → PIPE_PRI when count_next==0. A push that coincides with the last pop keeps the state in MDU_FORCE.
- Ordering:
  - Each source is written in its own arrival order.
  - WAW/RAW ordering between the pipe and MDU for the same rd is guaranteed by the issue/hazard unit, not by this block.

## Timing
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - state=PIPE_PRI, count=0, pointers=0, starve_cnt=0.
  - Hence pipe_stall=0 and mdu_ready=1 during and after reset.
- Latency:
  - Pipe request accepted in cycle N → rf_* in cycle N+1.
  - MDU push in cycle N → earliest pop in N+1 → rf_* in N+2.
- rf_we is high for exactly one cycle per granted non-x0 write. When no grant occurs, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
- Stall onset: pipe_stall rises the cycle after the triggering push or count, never in the same cycle.
- Full FIFO: mdu_ready=0 for that cycle even if a pop is occurring. The MDU must hold mdu_* until accepted.
- Reset mid-operation: FIFO contents are discarded, an in-flight rf_we is cleared immediately (asynchronous), and pipe_stall drops immediately.

## Test plan
- After reset with no requests: rf_we=0, pipe_stall=0, mdu_ready=1. Then pipe request rd=5, data=0x1234 in cycle N → rf_we=1, waddr=5, wdata=0x1234 in N+1 only.
- Pipe requests continuous and one MDU push (rd=7, 0xAAAA_0001):
  - FIFO holds the entry; pipe_stall rises exactly STARVE_MAX cycles after the push.
  - The next cycle writes rd=7.
  - pipe_stall returns to 0 the cycle after the pop.
- Pipe requests continuous and two back-to-back MDU pushes (FIFO_DEPTH=2):
  - mdu_ready=0 the cycle after the second push; pipe_stall=1 next.
  - The two MDU writes appear in push order on consecutive cycles.
  - The stalled pipe write is then written unchanged.
- Pipe bubble (pipe_valid=1, pipe_wen=0) with one FIFO entry: the entry pops in that cycle and pipe_stall stays 0.
- Pipe write rd=0 and MDU result rd=0: both are consumed, rf_we never asserts, and FIFO count returns to 0.
- Assert rst while in MDU_FORCE with count=2: outputs go to reset values within the same cycle, and the drained entries never appear on rf_*.

Source files
------------

// File: rtl/wb_port_arb.sv
// wb_port_arb: arbitrates the single register-file write port between the
// in-order pipeline writeback and buffered out-of-order MDU results. MDU
// results are held in a small circular FIFO and drained into idle port
// cycles. A starvation counter forces a drain by stalling the pipeline.
module wb_port_arb #(
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        pipe_valid_i,
   input  logic        pipe_wen_i,
   input  logic [4:0]  pipe_rd_i,
   input  logic [31:0] pipe_wdata_i,
   output logic        pipe_stall_o,
   input  logic        mdu_valid_i,
   input  logic [4:0]  mdu_rd_i,
   input  logic [31:0] mdu_wdata_i,
   output logic        mdu_ready_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic {PIPE_PRI, MDU_FORCE} state_e;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   state_e          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic            rf_we_q, rf_we_d;
   logic [4:0]      rf_waddr_q, rf_waddr_d;
   logic [31:0]     rf_wdata_q, rf_wdata_d;
   ent_t            mem_q [FIFO_DEPTH];
   ent_t            head;
   logic            pipe_req, push, pop, grant_pipe;

   // Both handshake outputs come straight from registered state so no input
   // can reach them combinationally.
   assign pipe_stall_o = (state_q == MDU_FORCE);
   assign mdu_ready_o  = (count_q < CW'(FIFO_DEPTH));
   assign rf_we_o      = rf_we_q;
   assign rf_waddr_o   = rf_waddr_q;
   assign rf_wdata_o   = rf_wdata_q;
   assign head         = mem_q[rd_ptr_q];

   // Grant selection, FIFO bookkeeping, starvation tracking and next state.
   always_comb begin
      pipe_req   = pipe_valid_i & pipe_wen_i;
      push       = mdu_valid_i & mdu_ready_o;
      pop        = 1'b0;
      grant_pipe = 1'b0;
      state_d    = state_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;

      if (state_q == PIPE_PRI) begin
         if (pipe_req) grant_pipe = 1'b1;
         else          pop = (count_q != '0);
      end else begin
         // Forced drain: the held pipe request is left untouched.
         pop = (count_q != '0);
      end

      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);

      if (pop || count_q == '0 || state_q == MDU_FORCE)
         starve_d = '0;
      else if (starve_q != SW'(STARVE_MAX))
         starve_d = starve_q + SW'(1);
      else
         starve_d = starve_q;

      case (state_q)
         PIPE_PRI:
            if (count_d == CW'(FIFO_DEPTH) || starve_d == SW'(STARVE_MAX))
               state_d = MDU_FORCE;
         MDU_FORCE:
            if (count_d == '0) state_d = PIPE_PRI;
         default: state_d = PIPE_PRI;
      endcase

      // x0 writes occupy the port but never raise the enable.
      if (grant_pipe) begin
         rf_we_d    = (pipe_rd_i != 5'd0);
         rf_waddr_d = pipe_rd_i;
         rf_wdata_d = pipe_wdata_i;
      end else if (pop) begin
         rf_we_d    = (head.rd != 5'd0);
         rf_waddr_d = head.rd;
         rf_wdata_d = head.data;
      end
   end

   // Control state and registered write-port outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= PIPE_PRI;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         starve_q   <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         starve_q   <= starve_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   // FIFO storage; stale contents are harmless since count gates every read.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= '{rd: mdu_rd_i, data: mdu_wdata_i};
   end

endmodule

// File: tb/tb_wb_port_arb.sv
// Directed bench for wb_port_arb (FIFO_DEPTH=2, STARVE_MAX=8).
// Inputs change 1ns after a rising edge; outputs are sampled at that point.
module tb_wb_port_arb;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pipe_valid = 1'b0, pipe_wen = 1'b0;
   logic [4:0]  pipe_rd = '0;
   logic [31:0] pipe_wdata = '0;
   logic        pipe_stall;
   logic        mdu_valid = 1'b0;
   logic [4:0]  mdu_rd = '0;
   logic [31:0] mdu_wdata = '0;
   logic        mdu_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int checks = 0;
   int errors = 0;

   wb_port_arb #(.FIFO_DEPTH(2), .STARVE_MAX(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .pipe_valid_i(pipe_valid), .pipe_wen_i(pipe_wen),
      .pipe_rd_i(pipe_rd), .pipe_wdata_i(pipe_wdata),
      .pipe_stall_o(pipe_stall),
      .mdu_valid_i(mdu_valid), .mdu_rd_i(mdu_rd), .mdu_wdata_i(mdu_wdata),
      .mdu_ready_o(mdu_ready),
      .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pipe(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] d);
      pipe_valid = v; pipe_wen = w; pipe_rd = rd; pipe_wdata = d;
   endtask

   task automatic set_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      mdu_valid = v; mdu_rd = rd; mdu_wdata = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", rf_we); end
      checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", pipe_stall); end
      checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", mdu_ready); end
      step(); step();
      rst = 1'b0;
      step();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL post_rst_we got %b exp 0", rf_we); end
      checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL post_rst_addr_data got %0d/%h exp 0/0", rf_waddr, rf_wdata); end
      checks++; if (pipe_stall !== 1'b0 || mdu_ready !== 1'b1) begin errors++; $display("FAIL post_rst_hs got stall=%b ready=%b exp 0/1", pipe_stall, mdu_ready); end
   endtask

   task automatic test_pipe_write();
      set_pipe(1, 1, 5'd5, 32'h1234);
      step();
      set_pipe(0, 0, 5'd0, 32'd0);
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin errors++; $display("FAIL pipe_write got we=%b a=%0d d=%h exp 1/5/00001234", rf_we, rf_waddr, rf_wdata); end
      step();
      checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin errors++; $display("FAIL pipe_hold got we=%b a=%0d d=%h exp 0/5/00001234", rf_we, rf_waddr, rf_wdata); end
   endtask

   // One MDU entry starved by continuous pipe writes: stall appears after the
   // 8th edge following the push edge, the entry drains, then the pipe resumes.
   task automatic test_starve();
      set_pipe(1, 1, 5'd3, 32'h3333);
      set_mdu(1, 5'd7, 32'hAAAA_0001);
      step();
      set_mdu(0, 5'd0, 32'd0);
      for (int k = 1; k <= 8; k++) begin
         step();
         checks++; if (pipe_stall !== (k == 8)) begin errors++; $display("FAIL starve_stall k=%0d got %b exp %b", k, pipe_stall, (k == 8)); end
         checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin errors++; $display("FAIL starve_pipe k=%0d got we=%b a=%0d exp 1/3", k, rf_we, rf_waddr); end
      end
      step();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hAAAA_0001) begin errors++; $display("FAIL starve_pop got we=%b a=%0d d=%h exp 1/7/aaaa0001", rf_we, rf_waddr, rf_wdata); end
      checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_release got %b exp 0", pipe_stall); end
      step();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h3333) begin errors++; $display("FAIL starve_resume got we=%b a=%0d d=%h exp 1/3/00003333", rf_we, rf_waddr, rf_wdata); end
      set_pipe(0, 0, 5'd0, 32'd0);
      step();
   endtask

   // Two back-to-back pushes fill the FIFO and force an in-order drain.
   task automatic test_back_to_back();
      set_pipe(1, 1, 5'd9, 32'h9999);
      set_mdu(1, 5'd10, 32'h0000_000A);
      step();
      checks++; if (mdu_ready !== 1'b1 || pipe_stall !== 1'b0) begin errors++; $display("FAIL b2b_first got ready=%b stall=%b exp 1/0", mdu_ready, pipe_stall); end
      set_mdu(1, 5'd11, 32'h0000_000B);
      step();
      set_mdu(0, 5'd0, 32'd0);
      checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b exp 0", mdu_ready); end
      checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall got %b exp 1", pipe_stall); end
      checks++; if (rf_waddr !== 5'd9) begin errors++; $display("FAIL b2b_pipe got a=%0d exp 9", rf_waddr); end
      step();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'hA) begin errors++; $display("FAIL b2b_popA got we=%b a=%0d d=%h exp 1/10/0000000a", rf_we, rf_waddr, rf_wdata); end
      checks++; if (pipe_stall !== 1'b1 || mdu_ready !== 1'b1) begin errors++; $display("FAIL b2b_mid got stall=%b ready=%b exp 1/1", pipe_stall, mdu_ready); end
      step();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'hB) begin errors++; $display("FAIL b2b_popB got we=%b a=%0d d=%h exp 1/11/0000000b", rf_we, rf_waddr, rf_wdata); end
      checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL b2b_release got %b exp 0", pipe_stall); end
      step();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h9999) begin errors++; $display("FAIL b2b_held_pipe got we=%b a=%0d d=%h exp 1/9/00009999", rf_we, rf_waddr, rf_wdata); end
      set_pipe(0, 0, 5'd0, 32'd0);
      step();
   endtask

   // A bubble (valid without wen) leaves the port free for a FIFO pop.
   task automatic test_bubble();
      set_pipe(1, 1, 5'd4, 32'h4444);
      set_mdu(1, 5'd12, 32'h0000_C0DE);
      step();
      set_mdu(0, 5'd0, 32'd0);
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4) begin errors++; $display("FAIL bubble_pipe got we=%b a=%0d exp 1/4", rf_we, rf_waddr); end
      set_pipe(1, 0, 5'd6, 32'h6666);
      step();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hC0DE) begin errors++; $display("FAIL bubble_pop got we=%b a=%0d d=%h exp 1/12/0000c0de", rf_we, rf_waddr, rf_wdata); end
      checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL bubble_stall got %b exp 0", pipe_stall); end
      set_pipe(0, 0, 5'd0, 32'd0);
      step();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL bubble_idle got %b exp 0", rf_we); end
   endtask

   // x0 destinations are consumed from both sources with no write enable.
   task automatic test_x0();
      set_pipe(1, 1, 5'd0, 32'h5555);
      set_mdu(1, 5'd0, 32'h6666);
      step();
      set_pipe(0, 0, 5'd0, 32'd0);
      set_mdu(0, 5'd0, 32'd0);
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_pipe_we got %b exp 0", rf_we); end
      checks++; if (dut.count_q !== 2'd1) begin errors++; $display("FAIL x0_count_push got %0d exp 1", dut.count_q); end
      step();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_mdu_we got %b exp 0", rf_we); end
      checks++; if (dut.count_q !== 2'd0) begin errors++; $display("FAIL x0_count_drain got %0d exp 0", dut.count_q); end
   endtask

   // Reset while force-draining a full FIFO discards both entries.
   task automatic test_reset_mid();
      set_pipe(1, 1, 5'd13, 32'hD0D0);
      set_mdu(1, 5'd14, 32'hE0E0);
      step();
      set_mdu(1, 5'd15, 32'hF0F0);
      step();
      set_mdu(0, 5'd0, 32'd0);
      set_pipe(0, 0, 5'd0, 32'd0);
      checks++; if (pipe_stall !== 1'b1 || rf_we !== 1'b1) begin errors++; $display("FAIL rmid_pre got stall=%b we=%b exp 1/1", pipe_stall, rf_we); end
      rst = 1'b1;
      #1;
      checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL rmid_rf got we=%b a=%0d d=%h exp 0/0/0", rf_we, rf_waddr, rf_wdata); end
      checks++; if (pipe_stall !== 1'b0 || mdu_ready !== 1'b1) begin errors++; $display("FAIL rmid_hs got stall=%b ready=%b exp 0/1", pipe_stall, mdu_ready); end
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (rf_we !== 1'b0 || pipe_stall !== 1'b0) begin errors++; $display("FAIL rmid_after k=%0d got we=%b stall=%b exp 0/0", k, rf_we, pipe_stall); end
      end
   endtask

   initial begin
      test_reset();
      test_pipe_write();
      test_starve();
      test_back_to_back();
      test_bubble();
      test_x0();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
